// File: rtl/cvxif_copro_issue_unit_if.sv
// CV-X-IF issue/commit/result bundle between the CVA6 core (master) and the coprocessor (slave).
interface cvxif_copro_issue_unit_if #(
    parameter int XLEN    = 32,
    parameter int IdWidth = 3
);
    logic               issue_valid_i;
    logic               issue_ready_o;
    logic [31:0]        issue_instr_i;
    logic [IdWidth-1:0] issue_id_i;
    logic [3*XLEN-1:0]  issue_rs_i;
    logic               issue_accept_o;
    logic               issue_wb_o;
    logic               commit_valid_i;
    logic [IdWidth-1:0] commit_id_i;
    logic               commit_kill_i;
    logic               result_valid_o;
    logic               result_ready_i;
    logic [IdWidth-1:0] result_id_o;
    logic [XLEN-1:0]    result_data_o;
    logic [4:0]         result_rd_o;
    logic               busy_o;

    modport master (
        output issue_valid_i, issue_instr_i, issue_id_i, issue_rs_i,
        output commit_valid_i, commit_id_i, commit_kill_i, result_ready_i,
        input  issue_ready_o, issue_accept_o, issue_wb_o,
        input  result_valid_o, result_id_o, result_data_o, result_rd_o, busy_o
    );

    modport slave (
        input  issue_valid_i, issue_instr_i, issue_id_i, issue_rs_i,
        input  commit_valid_i, commit_id_i, commit_kill_i, result_ready_i,
        output issue_ready_o, issue_accept_o, issue_wb_o,
        output result_valid_o, result_id_o, result_data_o, result_rd_o, busy_o
    );
endinterface

// File: rtl/cvxif_copro_issue_unit.sv
// CV-X-IF coprocessor front end: decode, commit buffer and in-order execute pipe.
// Define CVXIF_DUALREAD_EN to enable rs3 and the multiply-add (mad) instruction.
module cvxif_copro_issue_unit #(
    parameter int NrInstr    = 3,
    parameter int XLEN       = 32,
    parameter int IdWidth    = 3,
    parameter int Depth      = 4,
    parameter int MulLatency = 2
) (
    input logic                     clk_i,
    input logic                     rst_i,
    cvxif_copro_issue_unit_if.slave bus
);
    localparam int PtrW = $clog2(Depth);
    localparam int CntW = PtrW + 1;
    localparam int OpW  = 2;
    localparam int Last = MulLatency - 1;

    localparam logic [OpW-1:0] OP_CUSTOM1 = 2'd0;
    localparam logic [OpW-1:0] OP_CUSTOM2 = 2'd1;
`ifdef CVXIF_DUALREAD_EN
    localparam logic [OpW-1:0] OP_MAD     = 2'd2;
    localparam logic           MadEn      = 1'b1;
`else
    localparam logic           MadEn      = 1'b0;
`endif

    function automatic logic [31:0] f_tbl_match(input int idx);
        case (idx)
            0:       f_tbl_match = 32'h0000_002B;
            1:       f_tbl_match = 32'h0000_005B;
            2:       f_tbl_match = 32'hC000_0033;
            default: f_tbl_match = 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [31:0] f_tbl_mask(input int idx);
        case (idx)
            0, 1:    f_tbl_mask = 32'h0000_007F;
            2:       f_tbl_mask = 32'hC000_007F;
            default: f_tbl_mask = 32'h0000_0000;
        endcase
    endfunction

    // Entries beyond the defined encodings are disabled so a zero mask never matches everything.
    function automatic logic f_tbl_en(input int idx);
        case (idx)
            0, 1:    f_tbl_en = 1'b1;
            2:       f_tbl_en = MadEn;
            default: f_tbl_en = 1'b0;
        endcase
    endfunction

`ifdef CVXIF_DUALREAD_EN
    function automatic logic [XLEN-1:0] f_exec(input logic [OpW-1:0] op, input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b, input logic [XLEN-1:0] c);
        logic [XLEN-1:0] res;
        if (op == OP_MAD) res = a * b + c;
        else              res = a + b;
        return res;
    endfunction
`else
    function automatic logic [XLEN-1:0] f_exec(input logic [OpW-1:0] op, input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
        return (op == OP_CUSTOM2) ? a + b : '0;
    endfunction
`endif

    logic                 w_dec_hit;
    logic [OpW-1:0]       w_dec_op;
    logic                 w_dec_wb;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_inject;
    logic                 w_head_go;
    logic                 w_head_kill;
    logic                 w_pipe_adv;
    logic                 w_cmt_new;
    logic [Depth-1:0]     w_cmt_hit;
    logic [XLEN-1:0]      w_head_data;
    logic                 w_res_vld;

    logic [PtrW-1:0]      r_head;
    logic [PtrW-1:0]      r_tail;
    logic [CntW-1:0]      r_count;
    logic [Depth-1:0]     r_buf_vld;
    logic [Depth-1:0]     r_buf_cmt;
    logic [Depth-1:0]     r_buf_kill;
    logic [IdWidth-1:0]   r_buf_id  [Depth];
    logic [OpW-1:0]       r_buf_op  [Depth];
    logic [4:0]           r_buf_rd  [Depth];
    logic [XLEN-1:0]      r_buf_rs1 [Depth];
    logic [XLEN-1:0]      r_buf_rs2 [Depth];
`ifdef CVXIF_DUALREAD_EN
    logic [XLEN-1:0]      r_buf_rs3 [Depth];
`else
    logic                 w_unused_rs3;
    assign w_unused_rs3 = ^bus.issue_rs_i[3*XLEN-1:2*XLEN];
`endif

    logic [MulLatency-1:0] r_vld_p;
    logic [MulLatency-1:0] r_wb_p;
    logic [IdWidth-1:0]    r_id_p   [MulLatency];
    logic [4:0]            r_rd_p   [MulLatency];
    logic [XLEN-1:0]       r_data_p [MulLatency];

    // Decode: iterate downwards so the lowest matching index is the last to assign.
    always_comb begin
        w_dec_hit = 1'b0;
        w_dec_op  = OP_CUSTOM1;
        for (int i = NrInstr - 1; i >= 0; i--) begin
            if (f_tbl_en(i) && ((bus.issue_instr_i & f_tbl_mask(i)) == f_tbl_match(i))) begin
                w_dec_hit = 1'b1;
                w_dec_op  = OpW'(i);
            end
        end
    end

    assign w_dec_wb           = w_dec_hit & (w_dec_op != OP_CUSTOM1);
    assign bus.issue_accept_o = bus.issue_valid_i & w_dec_hit;
    assign bus.issue_wb_o     = bus.issue_valid_i & w_dec_wb;
    assign bus.issue_ready_o  = (r_count < CntW'(Depth));
    assign w_push             = bus.issue_valid_i & bus.issue_ready_o & w_dec_hit;
    assign w_cmt_new          = bus.commit_valid_i & (bus.commit_id_i == bus.issue_id_i);

    always_comb begin
        for (int i = 0; i < Depth; i++) begin
            w_cmt_hit[i] = bus.commit_valid_i & r_buf_vld[i] & ~r_buf_cmt[i] &
                           (r_buf_id[i] == bus.commit_id_i);
        end
    end

    assign w_head_go   = r_buf_vld[r_head] & r_buf_cmt[r_head];
    assign w_head_kill = r_buf_kill[r_head];
    assign w_pop       = w_head_go & (w_head_kill | w_pipe_adv);
    assign w_inject    = w_head_go & ~w_head_kill & w_pipe_adv;

`ifdef CVXIF_DUALREAD_EN
    assign w_head_data = f_exec(r_buf_op[r_head], r_buf_rs1[r_head], r_buf_rs2[r_head], r_buf_rs3[r_head]);
`else
    assign w_head_data = f_exec(r_buf_op[r_head], r_buf_rs1[r_head], r_buf_rs2[r_head]);
`endif

    // Buffer control: pointers, occupancy and per-entry valid/commit/kill flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_buf_vld  <= '0;
            r_buf_cmt  <= '0;
            r_buf_kill <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop)  r_head <= r_head + 1'b1;
            r_count <= r_count + CntW'(w_push) - CntW'(w_pop);
            for (int i = 0; i < Depth; i++) begin
                if (w_push && (r_tail == PtrW'(i))) begin
                    r_buf_vld[i]  <= 1'b1;
                    r_buf_cmt[i]  <= w_cmt_new;
                    r_buf_kill[i] <= w_cmt_new & bus.commit_kill_i;
                end else begin
                    if (w_pop && (r_head == PtrW'(i))) r_buf_vld[i] <= 1'b0;
                    if (w_cmt_hit[i]) begin
                        r_buf_cmt[i]  <= 1'b1;
                        r_buf_kill[i] <= bus.commit_kill_i;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_buf_id[r_tail]  <= bus.issue_id_i;
            r_buf_op[r_tail]  <= w_dec_op;
            r_buf_rd[r_tail]  <= bus.issue_instr_i[11:7];
            r_buf_rs1[r_tail] <= bus.issue_rs_i[XLEN-1:0];
            r_buf_rs2[r_tail] <= bus.issue_rs_i[2*XLEN-1:XLEN];
`ifdef CVXIF_DUALREAD_EN
            r_buf_rs3[r_tail] <= bus.issue_rs_i[3*XLEN-1:2*XLEN];
`endif
        end
    end

    // Execute pipe: stage 0 takes the head, stage Last drives the result channel.
    assign w_res_vld  = r_vld_p[Last] & r_wb_p[Last];
    assign w_pipe_adv = ~(w_res_vld & ~bus.result_ready_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_vld_p <= '0;
        end else if (w_pipe_adv) begin
            r_vld_p[0] <= w_inject;
            for (int s = 1; s < MulLatency; s++) r_vld_p[s] <= r_vld_p[s-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_pipe_adv) begin
            r_wb_p[0]   <= (r_buf_op[r_head] != OP_CUSTOM1);
            r_id_p[0]   <= r_buf_id[r_head];
            r_rd_p[0]   <= r_buf_rd[r_head];
            r_data_p[0] <= w_head_data;
            for (int s = 1; s < MulLatency; s++) begin
                r_wb_p[s]   <= r_wb_p[s-1];
                r_id_p[s]   <= r_id_p[s-1];
                r_rd_p[s]   <= r_rd_p[s-1];
                r_data_p[s] <= r_data_p[s-1];
            end
        end
    end

    // Data stages are not reset, so the visible result fields are gated by valid.
    assign bus.result_valid_o = w_res_vld;
    assign bus.result_id_o    = w_res_vld ? r_id_p[Last]   : '0;
    assign bus.result_data_o  = w_res_vld ? r_data_p[Last] : '0;
    assign bus.result_rd_o    = w_res_vld ? r_rd_p[Last]   : '0;
    assign bus.busy_o         = (r_count != '0) | (|r_vld_p);
endmodule

// File: tb/tb_cvxif_copro_issue_unit.sv
// Scoreboard bench for cvxif_copro_issue_unit: results are checked in order against queued expectations.
module tb_cvxif_copro_issue_unit;
    localparam int XLEN       = 32;
    localparam int IdWidth    = 3;
    localparam int Depth      = 4;
    localparam int MulLatency = 2;

    typedef struct {
        logic [IdWidth-1:0] id;
        logic [XLEN-1:0]    data;
        logic [4:0]         rd;
    } exp_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk_i = ~clk_i;

    cvxif_copro_issue_unit_if #(.XLEN(XLEN), .IdWidth(IdWidth)) bus ();

    cvxif_copro_issue_unit #(
        .NrInstr(3), .XLEN(XLEN), .IdWidth(IdWidth), .Depth(Depth), .MulLatency(MulLatency)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .bus  (bus)
    );

    function automatic logic [31:0] c2(input logic [4:0] rd);
        return 32'h0000_005B | {20'h0, rd, 7'h0};
    endfunction

    function automatic logic [XLEN-1:0] model(input logic [31:0] instr, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b, input logic [XLEN-1:0] c);
        if (instr[6:0] == 7'h5B) return a + b;
        return a * b + c;
    endfunction

    // Result monitor: every handshake pops one expectation.
    always @(negedge clk_i) begin
        if (!rst_i && bus.result_valid_o && bus.result_ready_i) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_result got id=%0d data=%h rd=%0d, required none",
                         bus.result_id_o, bus.result_data_o, bus.result_rd_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (bus.result_id_o !== e.id || bus.result_data_o !== e.data || bus.result_rd_o !== e.rd) begin
                    n_err++;
                    $display("FAIL result got id=%0d data=%h rd=%0d, required id=%0d data=%h rd=%0d",
                             bus.result_id_o, bus.result_data_o, bus.result_rd_o, e.id, e.data, e.rd);
                end
            end
        end
    end

    task automatic drive(input logic iv, input logic [31:0] instr, input logic [IdWidth-1:0] id,
                         input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic [XLEN-1:0] c,
                         input logic cv, input logic [IdWidth-1:0] cid, input logic ck,
                         output logic acc, output logic wb, output logic rdy);
        bus.issue_valid_i  = iv;
        bus.issue_instr_i  = instr;
        bus.issue_id_i     = id;
        bus.issue_rs_i     = {c, b, a};
        bus.commit_valid_i = cv;
        bus.commit_id_i    = cid;
        bus.commit_kill_i  = ck;
        #1;
        acc = bus.issue_accept_o;
        wb  = bus.issue_wb_o;
        rdy = bus.issue_ready_o;
        @(posedge clk_i);
        #1;
        bus.issue_valid_i  = 1'b0;
        bus.commit_valid_i = 1'b0;
        bus.commit_kill_i  = 1'b0;
    endtask

    task automatic issue(input logic [31:0] instr, input logic [IdWidth-1:0] id, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, input logic [XLEN-1:0] c,
                         output logic acc, output logic wb, output logic rdy);
        drive(1'b1, instr, id, a, b, c, 1'b0, '0, 1'b0, acc, wb, rdy);
    endtask

    task automatic commit(input logic [IdWidth-1:0] id, input logic kill);
        logic acc, wb, rdy;
        drive(1'b0, 32'h0, '0, '0, '0, '0, 1'b1, id, kill, acc, wb, rdy);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 80; k++) begin
            if (exp_q.size() == 0 && !bus.busy_o) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic test_reset();
        bus.issue_valid_i  = 1'b0;
        bus.issue_instr_i  = '0;
        bus.issue_id_i     = '0;
        bus.issue_rs_i     = '0;
        bus.commit_valid_i = 1'b0;
        bus.commit_id_i    = '0;
        bus.commit_kill_i  = 1'b0;
        bus.result_ready_i = 1'b1;
        rst_i = 1'b1;
        idle(3);
        rst_i = 1'b0;
        #1;
        n_vec++;
        if (bus.issue_ready_o !== 1'b1 || bus.result_valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl got ready=%b rvalid=%b busy=%b, required 1 0 0",
                     bus.issue_ready_o, bus.result_valid_o, bus.busy_o);
        end
        n_vec++;
        if (bus.result_id_o !== '0 || bus.result_data_o !== '0 || bus.result_rd_o !== '0) begin
            n_err++;
            $display("FAIL reset_data got id=%0d data=%h rd=%0d, required 0 0 0",
                     bus.result_id_o, bus.result_data_o, bus.result_rd_o);
        end
    endtask

    task automatic test_custom2();
        logic acc, wb, rdy;
        bit   ok;
        issue(32'h0000_005B, 3'd1, 32'd5, 32'd7, 32'd0, acc, wb, rdy);
        n_vec++;
        if (acc !== 1'b1 || wb !== 1'b1 || rdy !== 1'b1) begin
            n_err++;
            $display("FAIL c2_issue got acc=%b wb=%b rdy=%b, required 1 1 1", acc, wb, rdy);
        end
        exp_q.push_back('{id: 3'd1, data: 32'd12, rd: 5'd0});
        commit(3'd1, 1'b0);
        for (int k = 0; k < MulLatency; k++) begin
            n_vec++;
            if (bus.result_valid_o !== 1'b0) begin
                n_err++;
                $display("FAIL c2_early k=%0d got rvalid=%b, required 0", k, bus.result_valid_o);
            end
            @(posedge clk_i);
            #1;
        end
        n_vec++;
        if (bus.result_valid_o !== 1'b1) begin
            n_err++;
            $display("FAIL c2_latency got rvalid=%b, required 1", bus.result_valid_o);
        end
        wait_drain(ok);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL c2_drain got pending=%0d, required 0", exp_q.size());
        end
        issue(32'h0000_0033, 3'd2, 32'd1, 32'd1, 32'd0, acc, wb, rdy);
        n_vec++;
        if (acc !== 1'b0 || wb !== 1'b0 || bus.busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL nomatch got acc=%b wb=%b busy=%b, required 0 0 0", acc, wb, bus.busy_o);
        end
    endtask

    task automatic test_mad();
        logic acc, wb, rdy;
        bit   ok;
        issue(32'hC000_02B3, 3'd2, 32'd3, 32'd4, 32'hFFFF_FFFE, acc, wb, rdy);
`ifdef CVXIF_DUALREAD_EN
        n_vec++;
        if (acc !== 1'b1 || wb !== 1'b1) begin
            n_err++;
            $display("FAIL mad_issue got acc=%b wb=%b, required 1 1", acc, wb);
        end
        exp_q.push_back('{id: 3'd2, data: 32'h0000_000A, rd: 5'd5});
        commit(3'd2, 1'b0);
`else
        n_vec++;
        if (acc !== 1'b0 || wb !== 1'b0 || bus.busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL mad_disabled got acc=%b wb=%b busy=%b, required 0 0 0", acc, wb, bus.busy_o);
        end
`endif
        wait_drain(ok);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL mad_drain got pending=%0d, required 0", exp_q.size());
        end
    endtask

    task automatic test_full();
        logic acc, wb, rdy;
        bit   ok;
        logic [31:0] ins;
        for (int i = 0; i < Depth; i++) begin
            ins = c2(5'(i + 1));
            issue(ins, IdWidth'(i), XLEN'(i * 10), XLEN'(i), '0, acc, wb, rdy);
            n_vec++;
            if (acc !== 1'b1 || rdy !== 1'b1) begin
                n_err++;
                $display("FAIL full_fill i=%0d got acc=%b rdy=%b, required 1 1", i, acc, rdy);
            end
            exp_q.push_back('{id: IdWidth'(i), data: model(ins, XLEN'(i * 10), XLEN'(i), '0), rd: 5'(i + 1)});
        end
        issue(c2(5'd9), 3'd4, 32'd1, 32'd2, '0, acc, wb, rdy);
        n_vec++;
        if (rdy !== 1'b0 || acc !== 1'b1) begin
            n_err++;
            $display("FAIL full_5th got rdy=%b acc=%b, required 0 1", rdy, acc);
        end
        commit(3'd0, 1'b0);
        n_vec++;
        if (bus.issue_ready_o !== 1'b0) begin
            n_err++;
            $display("FAIL full_before_pop got ready=%b, required 0", bus.issue_ready_o);
        end
        idle(1);
        n_vec++;
        if (bus.issue_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL full_after_pop got ready=%b, required 1", bus.issue_ready_o);
        end
        for (int i = 1; i < Depth; i++) commit(IdWidth'(i), 1'b0);
        wait_drain(ok);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL full_drain got pending=%0d, required 0", exp_q.size());
        end
    endtask

    task automatic test_kill();
        logic acc, wb, rdy;
        bit   ok;
        issue(c2(5'd7), 3'd2, 32'd100, 32'd1, '0, acc, wb, rdy);
        issue(c2(5'd8), 3'd3, 32'd20, 32'd22, '0, acc, wb, rdy);
        exp_q.push_back('{id: 3'd3, data: 32'd42, rd: 5'd8});
        commit(3'd2, 1'b1);
        commit(3'd3, 1'b0);
        wait_drain(ok);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL kill_drain got pending=%0d, required 0", exp_q.size());
        end
        drive(1'b1, 32'h0000_0AAB, 3'd5, 32'd1, 32'd2, '0, 1'b1, 3'd5, 1'b0, acc, wb, rdy);
        n_vec++;
        if (acc !== 1'b1 || wb !== 1'b0) begin
            n_err++;
            $display("FAIL c1_issue got acc=%b wb=%b, required 1 0", acc, wb);
        end
        n_vec++;
        if (bus.busy_o !== 1'b1) begin
            n_err++;
            $display("FAIL c1_busy got busy=%b, required 1", bus.busy_o);
        end
        wait_drain(ok);
        n_vec++;
        if (!ok || bus.busy_o !== 1'b0) begin
            n_err++;
            $display("FAIL c1_idle got busy=%b, required 0", bus.busy_o);
        end
    endtask

    task automatic test_stall();
        logic acc, wb, rdy;
        bit   ok;
        logic [IdWidth-1:0] s_id;
        logic [XLEN-1:0]    s_data;
        logic [4:0]         s_rd;
        logic [31:0]        ins;
        bus.result_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ins = c2(5'(i + 10));
            issue(ins, IdWidth'(i), XLEN'(1000 + i), XLEN'(7 * i), '0, acc, wb, rdy);
            exp_q.push_back('{id: IdWidth'(i), data: model(ins, XLEN'(1000 + i), XLEN'(7 * i), '0), rd: 5'(i + 10)});
        end
        for (int i = 0; i < 3; i++) commit(IdWidth'(i), 1'b0);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (bus.result_valid_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
            idle(1);
        end
        n_vec++;
        if (!ok || bus.result_id_o !== 3'd0) begin
            n_err++;
            $display("FAIL stall_first got rvalid=%b id=%0d, required 1 0", bus.result_valid_o, bus.result_id_o);
        end
        s_id   = bus.result_id_o;
        s_data = bus.result_data_o;
        s_rd   = bus.result_rd_o;
        for (int k = 0; k < 10; k++) begin
            idle(1);
            n_vec++;
            if (bus.result_valid_o !== 1'b1 || bus.result_id_o !== s_id ||
                bus.result_data_o !== s_data || bus.result_rd_o !== s_rd) begin
                n_err++;
                $display("FAIL stall_hold k=%0d got v=%b id=%0d data=%h rd=%0d, required 1 %0d %h %0d",
                         k, bus.result_valid_o, bus.result_id_o, bus.result_data_o, bus.result_rd_o,
                         s_id, s_data, s_rd);
            end
        end
        bus.result_ready_i = 1'b1;
        wait_drain(ok);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL stall_drain got pending=%0d, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        logic acc, wb, rdy;
        bit   ok;
        for (int i = 0; i < 3; i++) issue(c2(5'd1), IdWidth'(i), 32'd1, 32'd1, '0, acc, wb, rdy);
        commit(3'd0, 1'b0);
        idle(1);
        exp_q.delete();
        rst_i = 1'b1;
        idle(1);
        n_vec++;
        if (bus.result_valid_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.issue_ready_o !== 1'b1) begin
            n_err++;
            $display("FAIL midreset got rvalid=%b busy=%b ready=%b, required 0 0 1",
                     bus.result_valid_o, bus.busy_o, bus.issue_ready_o);
        end
        rst_i = 1'b0;
        commit(3'd1, 1'b0);
        idle(6);
        n_vec++;
        if (bus.busy_o !== 1'b0 || bus.result_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL postreset_quiet got busy=%b rvalid=%b, required 0 0", bus.busy_o, bus.result_valid_o);
        end
        issue(c2(5'd4), 3'd6, 32'hFFFF_FFFF, 32'd2, '0, acc, wb, rdy);
        exp_q.push_back('{id: 3'd6, data: 32'd1, rd: 5'd4});
        commit(3'd6, 1'b0);
        wait_drain(ok);
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL postreset_drain got pending=%0d, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_custom2();
        test_mad();
        test_full();
        test_kill();
        test_stall();
        test_reset_mid();
        idle(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
